// File: rtl/qmult_seq_if.sv
// ----------------------------------------------------------------------------
// qmult_seq_if
//   Operand / result bundle for the sequential fixed-point multiplier. It uses
//   the same start/complete/overflow handshake as the radix-2 divider, so one
//   controller can sequence either unit.
//
//   Signals
//     i_multiplicand  N  signed operand A   (controller -> multiplier)
//     i_multiplier    N  signed operand B   (controller -> multiplier)
//     i_start         1  request            (controller -> multiplier)
//     o_result_out    N  signed product     (multiplier -> controller)
//     o_complete      1  idle / result valid (multiplier -> controller)
//     o_overflow      1  product not representable (multiplier -> controller)
//
//   Modports: master = controller side, slave = multiplier side.
// ----------------------------------------------------------------------------
interface qmult_seq_if #(
    parameter int N = 32
);
    logic [N-1:0] i_multiplicand;
    logic [N-1:0] i_multiplier;
    logic         i_start;
    logic [N-1:0] o_result_out;
    logic         o_complete;
    logic         o_overflow;

    modport master (
        output i_multiplicand, i_multiplier, i_start,
        input  o_result_out, o_complete, o_overflow
    );

    modport slave (
        input  i_multiplicand, i_multiplier, i_start,
        output o_result_out, o_complete, o_overflow
    );
endinterface

// File: rtl/qmult_seq.sv
// ----------------------------------------------------------------------------
// qmult_seq
//   Sequential signed fixed-point multiplier, Q(N-1-Q).Q two's complement.
//   Shift-add, one multiplier bit per clock. Sign/magnitude internally: the
//   magnitudes are multiplied and the sign is applied at the end, so the
//   most-negative operand is handled exactly.
//
//   Timing: accept on edge E0 (IDLE->LOAD), magnitudes formed at E1
//   (LOAD->RUN), N RUN cycles, result and o_complete on edge E(N+1).
//
//   Ports
//     i_clk   clock, rising edge
//     i_rst   asynchronous active-high reset
//     bus     qmult_seq_if.slave: operands, i_start, o_result_out,
//             o_complete, o_overflow
//
//   Parameters
//     Q  fractional bits (1 <= Q <= N-2)
//     N  word width including sign
//
//   Build option
//     QMULT_SATURATE_EN  when defined, an overflowed product saturates to the
//                        most positive / most negative value instead of
//                        wrapping. o_overflow is the same in both builds.
// ----------------------------------------------------------------------------
module qmult_seq #(
    parameter int Q = 15,
    parameter int N = 32
) (
    input  logic       i_clk,
    input  logic       i_rst,
    qmult_seq_if.slave bus
);

    localparam int CW = $clog2(N);
    // width of the truncated magnitude acc[2N-1:Q]
    localparam int MW = 2 * N - Q;
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic          w_accept;
    logic          w_done;
    logic          w_complete;

    logic [N-1:0]   r_a;
    logic [N-1:0]   r_b;
    logic           r_sign;
    logic [2*N-1:0] r_ma_sh;   // |A| shifted left by the iteration index
    logic [N-1:0]   r_mb;      // |B| shifted right, LSB selects the add
    logic [2*N-1:0] r_acc;
    logic [CW-1:0]  r_cnt;
    logic [N-1:0]   r_result;
    logic           r_overflow;

    logic [N-1:0]   w_abs_a;
    logic [N-1:0]   w_abs_b;
    logic [2*N-1:0] w_addend;
    logic [2*N-1:0] w_acc_sum;
    logic [MW-1:0]  w_m;
    logic [MW-1:0]  w_lim;
    logic           w_ovf;
    logic [N-1:0]   w_mag_lo;
    logic [N-1:0]   w_wrap;
    logic [N-1:0]   w_res_fmt;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_done      = 1'b0;
        w_complete  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_complete = 1'b1;
                if (bus.i_start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: w_state_nxt = S_RUN;
            S_RUN: begin
                if (r_cnt == '0) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    // N-bit magnitudes: -2^(N-1) negates to itself, which read as unsigned
    // is exactly 2^(N-1).
    assign w_abs_a = r_a[N-1] ? -r_a : r_a;
    assign w_abs_b = r_b[N-1] ? -r_b : r_b;

    assign w_addend  = r_mb[0] ? r_ma_sh : '0;
    assign w_acc_sum = r_acc + w_addend;

    // Result is formed from the post-add value so the final iteration's
    // contribution is included on the completion edge.
    assign w_m   = w_acc_sum[2*N-1:Q];
    // 2^(N-1)-1 for a positive result, 2^(N-1) for a negative one
    assign w_lim = {{(MW-N){1'b0}}, r_sign, {(N-1){~r_sign}}};
    assign w_ovf = (w_m > w_lim);

    // Negating a zero magnitude yields zero, so no negative zero appears.
    assign w_mag_lo = w_m[N-1:0];
    assign w_wrap   = r_sign ? -w_mag_lo : w_mag_lo;

`ifdef QMULT_SATURATE_EN
    assign w_res_fmt = !w_ovf ? w_wrap :
                       (r_sign ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}});
`else
    assign w_res_fmt = w_wrap;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_a        <= '0;
            r_b        <= '0;
            r_sign     <= 1'b0;
            r_ma_sh    <= '0;
            r_mb       <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_result   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a        <= bus.i_multiplicand;
                r_b        <= bus.i_multiplier;
                r_sign     <= bus.i_multiplicand[N-1] ^ bus.i_multiplier[N-1];
                r_overflow <= 1'b0;
            end
            if (r_state == S_LOAD) begin
                r_ma_sh <= {{N{1'b0}}, w_abs_a};
                r_mb    <= w_abs_b;
                r_acc   <= '0;
                r_cnt   <= CW'(N - 1);
            end
            if (r_state == S_RUN) begin
                r_acc   <= w_acc_sum;
                r_ma_sh <= r_ma_sh << 1;
                r_mb    <= r_mb >> 1;
                r_cnt   <= r_cnt - CNT_ONE;
                if (w_done) begin
                    r_result   <= w_res_fmt;
                    r_overflow <= w_ovf;
                end
            end
        end
    end

    assign bus.o_complete   = w_complete;
    assign bus.o_result_out = r_result;
    assign bus.o_overflow   = r_overflow;

endmodule

// File: doc/qmult_seq.md
Name: qmult_seq

Overview:
- Sequential signed fixed-point multiplier, Q(N-1-Q).Q two's-complement format; inverse of the radix-2 divider.
- Shares the divider's start/complete/overflow handshake, so the CNN datapath controller drives either unit with the same sequencing logic.
- Used for the fixed-point scaling/normalisation products that sit alongside the division steps.
- Shift-add, one multiplier bit per cycle; trades latency for area.

Parameters:
- Q, 15, number of fractional bits.
- N, 32, total word width including sign; 1 <= Q <= N-2.

Ports:
- i_clk  input  1  clock; all state changes on its rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_multiplicand  input  N  signed fixed-point operand A; sampled only on the accepting edge.
- i_multiplier  input  N  signed fixed-point operand B; sampled only on the accepting edge.
- i_start  input  1  request; accepted when high while o_complete=1.
- o_result_out  output  N  signed fixed-point product; held stable while o_complete=1.
- o_complete  output  1  1 = idle/result valid, 0 = busy.
- o_overflow  output  1  product not representable in N-bit Q format; valid while o_complete=1.

Behaviour:
- Clock and reset: one clock (i_clk); reset i_rst is asynchronous and active-high.
- Reset values: o_complete=1, o_result_out=0, o_overflow=0, state=IDLE.
  - Reset mid-operation aborts the operation immediately; no partial result is exposed.
- States: IDLE, LOAD, RUN.
- IDLE:
  - o_complete=1.
  - On i_start=1: latch both operands, latch sign = A[N-1]^B[N-1], clear o_overflow, drop o_complete, go to LOAD.
- LOAD (1 cycle): form N-bit magnitudes |A| and |B| from the latched operands.
  - Magnitudes are N bits wide, so -2^(N-1) gives magnitude 2^(N-1) and is handled exactly.
  - Clear the 2N-bit accumulator, load count=N-1, go to RUN.
- RUN (N cycles, count N-1..0):
  - If the LSB of the shifting |B| is 1, add |A| (left-shifted by the iteration index) into the accumulator.
  - Shift |B| right by one; decrement count.
  - On the count==0 cycle (the final add included), write outputs and go to IDLE.
- Result formation:
  - M = accumulator[2N-1:Q], i.e. magnitude truncated toward zero; discarded fraction bits are dropped.
  - Limit L = 2^(N-1)-1 when sign=0, 2^(N-1) when sign=1.
  - o_overflow = (M > L).
  - o_result_out = sign ? -(M[N-1:0]) : M[N-1:0], N-bit two's complement, with wrap when overflowed.
  - A zero product always gives result 0 with sign ignored, never negative zero.
- Latency: the accepting edge is E0; o_complete returns to 1 at edge E(N+1), i.e. 33 edges for N=32.
  - o_result_out and o_overflow are updated on that same edge.
- i_start while busy: ignored, no queueing. Operand changes while busy have no effect.
- i_start held high: a new operation is accepted on the first edge at which o_complete=1 is sampled. Back-to-back throughput is one result per N+2 cycles.
- Outputs from the previous operation are held until the completion edge of the next operation. o_overflow is cleared at acceptance.

Optional Feature:
- Macro: QMULT_SATURATE_EN.
- Defined: on overflow, o_result_out saturates to 0x7FFF_FFFF (sign=0) or 0x8000_0000 (sign=1), generalised to N. o_overflow is still asserted.
- Undefined: the wrap behaviour above. o_overflow is identical in both builds; only o_result_out differs on overflow.

Test Plan (Q=15, N=32):
1. A=0x0001_0000 (2.0), B=0xFFFE_8000 (-3.0), pulse i_start -> after 33 edges o_complete=1, o_result_out=0xFFFD_0000 (-6.0), o_overflow=0. Then A=0x0000_C000 x B=0x0000_C000 -> 0x0001_2000 (2.25).
2. A=0xFFFF_C000 (-0.5), B=0xFFFF_C000 -> 0x0000_2000 (0.25), overflow 0. A=0xFFFF_FFFF (-1 ulp) x B=0x0000_0001 -> 0x0000_0000, overflow 0 (truncation toward zero, no negative zero).
3. A=0x8000_0000 (-65536.0), B=0x0000_8000 (1.0) -> 0x8000_0000, overflow 0 (most-negative boundary is exact).
4. A=0x4000_0000 (32768.0), B=0x0001_0000 (2.0) -> o_overflow=1; o_result_out=0x8000_0000 without QMULT_SATURATE_EN, 0x7FFF_FFFF with it. Same magnitude with sign=1, A=0xC000_0000 x B: overflow 0, result 0x8000_0000.
5. During RUN, pulse i_start with new operands -> ignored; the original product is reported at E33. Then hold i_start high -> the next operation is accepted on the edge after completion.
6. Assert i_rst asynchronously mid-RUN (between clock edges) -> o_complete=1, o_result_out=0, o_overflow=0 immediately. After release, a fresh 2.0 x -3.0 completes correctly in 33 edges.
